// File: rtl/tone_sequencer_if.sv
// Control and status bundle between board logic and the tone sequencer.
// The master drives start/stop/loop; the slave (sequencer) returns registered status and the current note.
interface tone_sequencer_if #(
  parameter int unsigned HP_W = 20
);
  logic            start;
  logic            stop;
  logic            loop;
  logic            busy;
  logic            done;
  logic            tone_en;
  logic [HP_W-1:0] half_period;
  logic [2:0]      note_idx;
  logic            led;

  modport master (
    output start, stop, loop,
    input  busy, done, tone_en, half_period, note_idx, led
  );

  modport slave (
    input  start, stop, loop,
    output busy, done, tone_en, half_period, note_idx, led
  );
endinterface

// File: rtl/tone_sequencer.sv
// Steps an eight-note C4..C5 scale, presenting one half-period count plus enable to the square-wave stage.
// All outputs registered, one cycle from sampled start/stop; no backpressure, stop aborts from any state.
module tone_sequencer #(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned NOTE_CYCLES = 6_250_000,
  parameter int unsigned GAP_CYCLES  = 250_000,
  parameter int unsigned HP_W        = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  tone_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

  // Half-period in clock cycles for each note, truncated at elaboration.
  function automatic logic [HP_W-1:0] hp_of(input logic [2:0] idx);
    hp_of = '0;
    case (idx)
      3'd0: hp_of = HP_W'(CLK_FREQ / (2 * 262));
      3'd1: hp_of = HP_W'(CLK_FREQ / (2 * 294));
      3'd2: hp_of = HP_W'(CLK_FREQ / (2 * 330));
      3'd3: hp_of = HP_W'(CLK_FREQ / (2 * 349));
      3'd4: hp_of = HP_W'(CLK_FREQ / (2 * 392));
      3'd5: hp_of = HP_W'(CLK_FREQ / (2 * 440));
      3'd6: hp_of = HP_W'(CLK_FREQ / (2 * 494));
      3'd7: hp_of = HP_W'(CLK_FREQ / (2 * 523));
      default: hp_of = '0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tone_en_q, tone_en_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            led_q, led_d;
  logic            gap_end;
  logic            enter_note;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    idx_d      = idx_q;
    done_d     = 1'b0;
    led_d      = led_q;
    gap_end    = 1'b0;
    enter_note = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d    = S_NOTE;
          idx_d      = 3'd0;
          enter_note = 1'b1;
        end
      end
      S_NOTE: begin
        if (cnt_q == NOTE_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
          end else begin
            gap_end = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          gap_end = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // With no gap the end of a note doubles as the end of its gap.
    if (gap_end) begin
      if (idx_q != 3'd7) begin
        state_d    = S_NOTE;
        idx_d      = idx_q + 3'd1;
        enter_note = 1'b1;
      end else if (bus.loop) begin
        state_d    = S_NOTE;
        idx_d      = 3'd0;
        enter_note = 1'b1;
      end else begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        done_d  = 1'b1;
      end
    end

    if (enter_note) begin
      led_d = ~led_q;
    end

    // Stop wins over everything, including a same-cycle start or pass completion.
    if (bus.stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
      done_d  = 1'b0;
      led_d   = led_q;
    end

    // Outputs are computed from the next state so they register alongside it.
    tone_en_d = (state_d == S_NOTE);
    busy_d    = (state_d != S_IDLE);
    if (state_d == S_IDLE) begin
      hp_d = '0;
    end else if (state_d == S_NOTE) begin
      hp_d = hp_of(idx_d);
    end else begin
      hp_d = hp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tone_en_q <= 1'b0;
      hp_q      <= '0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tone_en_q <= tone_en_d;
      hp_q      <= hp_d;
      led_q     <= led_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.tone_en     = tone_en_q;
  assign bus.half_period = hp_q;
  assign bus.note_idx    = idx_q;
  assign bus.led         = led_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: expected notes are queued at start and retired as tone_en pulses end.
// A second instance with no gap checks the continuous-tone case.
module tb_tone_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_sequencer_if #(.HP_W(20)) bus ();
  tone_sequencer_if #(.HP_W(20)) bus0 ();

  tone_sequencer #(
    .CLK_FREQ(25_000_000), .NOTE_CYCLES(10), .GAP_CYCLES(2), .HP_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  tone_sequencer #(
    .CLK_FREQ(25_000_000), .NOTE_CYCLES(10), .GAP_CYCLES(0), .HP_W(20)
  ) dut_nogap (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  typedef struct {
    bit          is_done;
    logic [19:0] hp;
    logic [2:0]  idx;
    int          len;
  } ev_t;

  logic [19:0] hp_tab [8] = '{20'd47709, 20'd42517, 20'd37878, 20'd35816,
                              20'd31887, 20'd28409, 20'd25303, 20'd23900};

  ev_t         exp_q [$];
  logic [19:0] exp0_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push_note(input logic [19:0] hp, input logic [2:0] idx, input int len);
    ev_t e;
    e.is_done = 1'b0; e.hp = hp; e.idx = idx; e.len = len;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done();
    ev_t e;
    e.is_done = 1'b1; e.hp = '0; e.idx = '0; e.len = 0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_pass();
    for (int i = 0; i < 8; i++) push_note(hp_tab[i], 3'(i), 10);
  endfunction

  // Main-instance monitor: measures each tone_en pulse and each gap.
  int          run_len = 0, low_len = 0, led_toggles = 0, done_cnt = 0;
  logic        prev_en = 1'b0, prev_led = 1'b0, gap_valid = 1'b0;
  logic [19:0] cur_hp = '0;
  logic [2:0]  cur_idx = '0;

  task automatic retire_note();
    ev_t e;
    chk_eq("sb_pending_note", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_eq("ev_kind_note", e.is_done, 0);
      chk_eq("note_hp", cur_hp, e.hp);
      chk_eq("note_idx", cur_idx, e.idx);
      chk_eq("note_len", run_len, e.len);
    end
  endtask

  task automatic retire_done();
    ev_t e;
    chk_eq("sb_pending_done", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_eq("ev_kind_done", e.is_done, 1);
      chk_eq("done_hp_zero", bus.half_period, 0);
      chk_eq("done_busy_low", bus.busy, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en   = 1'b0;
      gap_valid = 1'b0;
      prev_led  = bus.led;
    end else begin
      if (bus.led !== prev_led) led_toggles++;
      prev_led = bus.led;
      if (bus.tone_en && !prev_en) begin
        if (gap_valid) chk_eq("gap_len", low_len, 2);
        run_len = 1;
        cur_hp  = bus.half_period;
        cur_idx = bus.note_idx;
      end else if (bus.tone_en) begin
        run_len++;
      end else if (prev_en) begin
        retire_note();
        gap_valid = bus.busy;
        low_len   = 1;
      end else if (bus.busy) begin
        low_len++;
      end else begin
        gap_valid = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        retire_done();
      end
      prev_en = bus.tone_en;
    end
  end

  // No-gap instance monitor: one continuous tone made of 10-cycle segments.
  int          seg0 = 0, run0 = 0;
  logic        prev_en0 = 1'b0;
  logic [19:0] cur_hp0 = '0;

  task automatic retire_seg0();
    logic [19:0] e;
    chk_eq("g0_pending", exp0_q.size() != 0, 1);
    if (exp0_q.size() != 0) begin
      e = exp0_q.pop_front();
      chk_eq("g0_seg_hp", cur_hp0, e);
      chk_eq("g0_seg_len", seg0, 10);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en0 = 1'b0;
    end else begin
      if (bus0.tone_en) begin
        if (!prev_en0) begin
          seg0 = 1; run0 = 1; cur_hp0 = bus0.half_period;
        end else if (bus0.half_period != cur_hp0) begin
          retire_seg0();
          seg0 = 1; run0++; cur_hp0 = bus0.half_period;
        end else begin
          seg0++; run0++;
        end
      end else if (prev_en0) begin
        retire_seg0();
        chk_eq("g0_continuous_len", run0, 80);
      end
      prev_en0 = bus0.tone_en;
    end
  end

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk_eq("start_lat_busy", bus.busy, 1);
    chk_eq("start_lat_tone", bus.tone_en, 1);
    chk_eq("start_lat_hp", bus.half_period, hp_tab[0]);
  endtask

  // Counts busy cycles from cycle 0, driving optional start/stop/loop events at given cycles.
  task automatic run_busy(input int limit, input int s1, input int s2, input int stop_at,
                          input int loop_off, output int n);
    int c = 0;
    while (bus.busy && c < limit) begin
      bus.start = (c == s1) || (c == s2);
      bus.stop  = (c == stop_at);
      if (c == loop_off) bus.loop = 1'b0;
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    n = c;
  endtask

  initial begin
    int n, bad, led0, done0, c0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    bus0.start = 1'b0; bus0.stop = 1'b0; bus0.loop = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_done", bus.done, 0);
    chk_eq("rst_tone", bus.tone_en, 0);
    chk_eq("rst_hp", bus.half_period, 0);
    chk_eq("rst_idx", bus.note_idx, 0);
    chk_eq("rst_led", bus.led, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy || bus.tone_en || bus.done || bus.led || bus.half_period != 0) bad++;
    end
    chk_eq("idle_quiet", bad, 0);

    // Single pass with ignored starts during NOTE (cycle 25) and GAP (cycle 34)
    led0 = led_toggles; done0 = done_cnt;
    push_pass(); push_done();
    pulse_start();
    run_busy(300, 25, 34, -1, -1, n);
    chk_eq("single_busy_len", n, 96);
    chk_eq("single_done_edge", bus.done, 1);
    chk_eq("single_hp_zero", bus.half_period, 0);
    repeat (2) @(negedge clk);
    chk_eq("single_led_toggles", led_toggles - led0, 8);
    chk_eq("single_done_pulses", done_cnt - done0, 1);

    // Loop, dropping loop during note 3 of the second pass
    led0 = led_toggles; done0 = done_cnt;
    push_pass(); push_pass(); push_done();
    bus.loop = 1'b1;
    pulse_start();
    run_busy(400, -1, -1, -1, 135, n);
    chk_eq("loop_busy_len", n, 192);
    repeat (2) @(negedge clk);
    chk_eq("loop_led_toggles", led_toggles - led0, 16);
    chk_eq("loop_done_pulses", done_cnt - done0, 1);

    // Stop during the fifth cycle of note 4, then a fresh start
    done0 = done_cnt;
    for (int i = 0; i < 4; i++) push_note(hp_tab[i], 3'(i), 10);
    push_note(hp_tab[4], 3'd4, 5);
    pulse_start();
    run_busy(300, -1, -1, 52, -1, n);
    chk_eq("stop_busy_len", n, 53);
    chk_eq("stop_tone", bus.tone_en, 0);
    chk_eq("stop_hp", bus.half_period, 0);
    chk_eq("stop_idx", bus.note_idx, 0);
    chk_eq("stop_done", bus.done, 0);
    repeat (3) @(negedge clk);
    chk_eq("stop_no_done", done_cnt - done0, 0);
    push_pass(); push_done();
    pulse_start();
    run_busy(300, -1, -1, -1, -1, n);
    chk_eq("restart_busy_len", n, 96);

    // start and stop together in IDLE
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_eq("startstop_busy", bus.busy, 0);
    chk_eq("startstop_tone", bus.tone_en, 0);
    repeat (10) @(negedge clk);
    chk_eq("startstop_sb_empty", exp_q.size(), 0);

    // No-gap instance: 80 continuous cycles of tone
    for (int i = 0; i < 8; i++) exp0_q.push_back(hp_tab[i]);
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk) bus0.start = 1'b0;
    c0 = 0;
    while (bus0.busy && c0 < 300) begin
      @(negedge clk);
      c0++;
    end
    chk_eq("g0_busy_len", c0, 80);
    chk_eq("g0_done", bus0.done, 1);
    repeat (2) @(negedge clk);
    chk_eq("g0_sb_empty", exp0_q.size(), 0);

    // Async reset during note 2
    push_note(hp_tab[0], 3'd0, 10);
    push_note(hp_tab[1], 3'd1, 10);
    pulse_start();
    run_busy(28, -1, -1, -1, -1, n);
    chk_eq("arst_pre_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_busy", bus.busy, 0);
    chk_eq("arst_tone", bus.tone_en, 0);
    chk_eq("arst_hp", bus.half_period, 0);
    chk_eq("arst_idx", bus.note_idx, 0);
    chk_eq("arst_led", bus.led, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy || bus.tone_en) bad++;
    end
    chk_eq("arst_no_resume", bad, 0);
    chk_eq("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a fixed eight-note scale (C4 to C5) by stepping through a note table and presenting one half-period count at a time, with an enable, to the programmable square-wave stage that drives the differential speaker outputs. A start/stop/loop control interface lets board logic or a button debouncer trigger playback. Each note lasts a programmable time and is followed by a programmable silent gap. The block owns note timing only; waveform generation is done downstream.

## Interface
- CLK_FREQ, 25_000_000: system clock in Hz; used only to compute the note table.
- NOTE_CYCLES, 6_250_000: clock cycles each note sounds (250 ms at 25 MHz); must be ≥ 1.
- GAP_CYCLES, 250_000: silent clock cycles after each note (10 ms); 0 means no gap.
- HP_W, 20: width of the half-period output.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin playback from note 0; sampled only in IDLE.
- stop  input  1  abort playback; acts in any state.
- loop  input  1  level; sampled at the end of the last gap to decide restart vs finish.
- busy  output  1  high in NOTE and GAP.
- done  output  1  one-cycle pulse when a non-looped pass completes.
- tone_en  output  1  high while a note sounds; downstream stage outputs silence when low.
- half_period  output  HP_W  half-period count for the current note (clock cycles).
- note_idx  output  3  index of the current note, 0 to 7.
- led  output  1  toggles at the start of every note.

## Operation
- Note table: frequency f[i] = 262, 294, 330, 349, 392, 440, 494, 523 Hz for i = 0..7.
  - table[i] = CLK_FREQ / (2*f[i]), computed at elaboration with integer truncation.
  - At 25 MHz the values are 47709, 42517, 37878, 35816, 31887, 28409, 25303, 23900.
- Duration counter: 32 bits. It counts 0 to NOTE_CYCLES-1 in NOTE and 0 to GAP_CYCLES-1 in GAP, and clears on every state change.
- FSM states are IDLE, NOTE and GAP.
- IDLE:
  - tone_en=0, half_period=0, busy=0.
  - start=1 and stop=0 → NOTE with note_idx=0.
- NOTE:
  - tone_en=1, half_period=table[note_idx].
  - On the last count:
    - GAP_CYCLES>0 → GAP.
    - GAP_CYCLES=0 → behave exactly as at the end of GAP.
- GAP:
  - tone_en=0; half_period holds its value.
  - On the last count:
    - note_idx<7 → NOTE with note_idx+1.
    - note_idx=7 and loop=1 → NOTE with note_idx=0.
    - note_idx=7 and loop=0 → IDLE, and done=1 for that one cycle.
- stop=1 in any state → IDLE on the next edge.
  - note_idx=0, counter=0, no done pulse.
  - stop overrides start in the same cycle.
- start while busy is ignored.
- led toggles on every entry into NOTE.
- Reset values: state IDLE, counter 0, busy 0, done 0, tone_en 0, half_period 0, note_idx 0, led 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start latency: if start is sampled high at edge k, then tone_en, busy and half_period are valid starting in the cycle after edge k.
- Note timing: tone_en stays high for exactly NOTE_CYCLES cycles per note, then low for exactly GAP_CYCLES cycles.
- Non-looped pass: busy stays high for 8*(NOTE_CYCLES+GAP_CYCLES) cycles.
  - done is high in the first cycle busy is low.
  - half_period returns to 0 in that same cycle.
- Stop: busy and tone_en are low in the cycle after stop is sampled.
- Reset: assertion of rst_n clears all outputs immediately, without a clock edge. Deassertion takes effect at the next clk edge.

## Test plan
Benches use NOTE_CYCLES=10, GAP_CYCLES=2 and CLK_FREQ=25_000_000 unless stated.
- Reset: hold rst_n=0 and toggle clk → every output is 0. Release, with start=0 for 20 cycles → state stays IDLE and outputs stay 0.
- Single pass: one-cycle start pulse →
  - Eight tone_en pulses of 10 cycles, each followed by 2 cycles low.
  - half_period sequence is 47709 … 23900; note_idx runs 0..7; led toggles 8 times.
  - busy is high for 96 cycles; exactly one done pulse, coincident with half_period returning to 0.
- Loop: loop=1 then start →
  - After the note 7 gap, note_idx returns to 0 with no done pulse.
  - Drop loop during note 3 of the second pass → playback finishes after note 7 with one done pulse.
- Stop: assert stop during cycle 5 of note 4 →
  - Next cycle: busy=0, tone_en=0, half_period=0, note_idx=0, no done.
  - A new start then begins at note 0 with a full 10-cycle note.
- Ignored or overridden starts:
  - start pulses during NOTE and GAP → sequence timing unchanged.
  - start and stop together in IDLE → block stays in IDLE.
  - GAP_CYCLES=0 → tone_en stays high for a continuous 80 cycles, with half_period changing every 10 cycles.
- Async reset mid-note: drop rst_n between clock edges during note 2 → all outputs are 0 before the next edge. After release, playback does not resume without a new start.
